// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I pipeline types for the EX/MEM stage register and its skid buffer
package riscv_pkg;
  localparam int PKG_XLEN = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_e;
  typedef struct packed {
    logic [PKG_XLEN-1:0] alu_data;
    logic [PKG_XLEN-1:0] st_data;
    logic [PKG_XLEN-1:0] pc;
    logic [4:0]          rd_addr;
    logic                rd_wren;
    logic                mem_wren;
    logic                mem_rden;
    wb_sel_e             wb_sel;
  } ex_mem_t;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: two-entry (main + skid) valid/ready register slice with flush; ready_o is registered
module pipe_skid_buf #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);
  logic main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  T main_q, main_d, skid_q, skid_d;
  logic accept, deliver, load_main, load_skid;
  assign ready_o = ~skid_valid_q;
  assign valid_o = main_valid_q;
  assign data_o  = main_q;
  assign accept  = valid_i & ready_o;
  assign deliver = main_valid_q & ready_i;
  assign load_main = (deliver | ~main_valid_q) & accept & ~flush_i;
  assign load_skid = accept & main_valid_q & ~deliver & ~flush_i;
  always_comb begin
    main_valid_d = flush_i ? 1'b0 :
                   (deliver & skid_valid_q) ? 1'b1 :
                   load_main ? 1'b1 :
                   deliver ? 1'b0 : main_valid_q;
    main_d       = (deliver & skid_valid_q & ~flush_i) ? skid_q :
                   load_main ? data_i : main_q;
    skid_valid_d = flush_i ? 1'b0 :
                   (deliver & skid_valid_q) ? 1'b0 :
                   load_skid ? 1'b1 : skid_valid_q;
    skid_d       = load_skid ? data_i : skid_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end
endmodule

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX/MEM stage register with x0 write masking and a forwarding tap.
// Forwarding outputs are live only when EX_MEM_FWD_EN is defined; otherwise tied to 0.
module ex_mem_pipe_reg
  import riscv_pkg::*;
#(
  parameter int XLEN = PKG_XLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_wren_i,
  input  logic            mem_wren_i,
  input  logic            mem_rden_i,
  input  logic [1:0]      wb_sel_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] alu_data_o,
  output logic [XLEN-1:0] st_data_o,
  output logic [XLEN-1:0] pc_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wren_o,
  output logic            mem_wren_o,
  output logic            mem_rden_o,
  output logic [1:0]      wb_sel_o,
  output logic            fwd_en_o,
  output logic [4:0]      fwd_rd_addr_o,
  output logic [XLEN-1:0] fwd_data_o
);
  ex_mem_t in_s, out_s;
  // x0 is masked at capture so neither the MEM stage nor the forwarding tap ever sees a write to it
  assign in_s = '{
    alu_data: alu_data_i,
    st_data:  st_data_i,
    pc:       pc_i,
    rd_addr:  rd_addr_i,
    rd_wren:  rd_wren_i & (rd_addr_i != REG_ZERO),
    mem_wren: mem_wren_i,
    mem_rden: mem_rden_i,
    wb_sel:   wb_sel_e'(wb_sel_i)
  };
  pipe_skid_buf #(.T(ex_mem_t)) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (in_s),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (out_s)
  );
  assign alu_data_o = out_s.alu_data;
  assign st_data_o  = out_s.st_data;
  assign pc_o       = out_s.pc;
  assign rd_addr_o  = out_s.rd_addr;
  assign rd_wren_o  = out_s.rd_wren;
  assign mem_wren_o = out_s.mem_wren;
  assign mem_rden_o = out_s.mem_rden;
  assign wb_sel_o   = out_s.wb_sel;
`ifdef EX_MEM_FWD_EN
  // load data is not available until the MEM stage, so loads are not forwardable here
  assign fwd_en_o      = valid_o & out_s.rd_wren & (out_s.wb_sel != WB_MEM);
  assign fwd_rd_addr_o = out_s.rd_addr;
  assign fwd_data_o    = out_s.alu_data;
`else
  assign fwd_en_o      = 1'b0;
  assign fwd_rd_addr_o = '0;
  assign fwd_data_o    = '0;
`endif
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb_ex_mem_pipe_reg: directed + random stimulus checked against a two-deep FIFO reference model
module tb_ex_mem_pipe_reg;
  typedef struct {
    logic [31:0] alu, st, pc;
    logic [4:0]  rd;
    logic        wren, mw, mr;
    logic [1:0]  wb;
  } ent_t;
  logic clk = 1'b0;
  logic rst_ni, flush_i, valid_i, ready_o, ready_i, valid_o;
  logic [31:0] alu_data_i, st_data_i, pc_i, alu_data_o, st_data_o, pc_o, fwd_data_o;
  logic [4:0] rd_addr_i, rd_addr_o, fwd_rd_addr_o;
  logic rd_wren_i, mem_wren_i, mem_rden_i, rd_wren_o, mem_wren_o, mem_rden_o, fwd_en_o;
  logic [1:0] wb_sel_i, wb_sel_o;
  ent_t q[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ex_mem_pipe_reg #(.XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .alu_data_i(alu_data_i), .st_data_i(st_data_i), .pc_i(pc_i), .rd_addr_i(rd_addr_i),
    .rd_wren_i(rd_wren_i), .mem_wren_i(mem_wren_i), .mem_rden_i(mem_rden_i), .wb_sel_i(wb_sel_i),
    .valid_o(valid_o), .ready_i(ready_i), .alu_data_o(alu_data_o), .st_data_o(st_data_o),
    .pc_o(pc_o), .rd_addr_o(rd_addr_o), .rd_wren_o(rd_wren_o), .mem_wren_o(mem_wren_o),
    .mem_rden_o(mem_rden_o), .wb_sel_o(wb_sel_o), .fwd_en_o(fwd_en_o),
    .fwd_rd_addr_o(fwd_rd_addr_o), .fwd_data_o(fwd_data_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic ent_t mk(input logic [31:0] a, input logic [4:0] rd, input logic [1:0] wb);
    ent_t e;
    e.alu = a; e.st = $urandom; e.pc = $urandom; e.rd = rd; e.wren = 1'b1;
    e.mw = 1'($urandom); e.mr = 1'($urandom); e.wb = wb;
    return e;
  endfunction
  function automatic ent_t rnd();
    ent_t e;
    e = mk($urandom, 5'($urandom_range(0, 7)), 2'($urandom));
    e.wren = 1'($urandom);
    return e;
  endfunction
  // one clock: drive inputs, advance the model at the edge, then compare every visible output
  task automatic step(input logic rst, input logic f, input logic v, input logic r, input ent_t e);
    logic acc;
    ent_t m;
    ent_t h;
    logic exp_fe;
    rst_ni = rst; flush_i = f; valid_i = v; ready_i = r;
    alu_data_i = e.alu; st_data_i = e.st; pc_i = e.pc; rd_addr_i = e.rd;
    rd_wren_i = e.wren; mem_wren_i = e.mw; mem_rden_i = e.mr; wb_sel_i = e.wb;
    @(posedge clk);
    if (!rst || f) q.delete();
    else begin
      acc = v && (q.size() < 2);
      if (r && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        m = e;
        m.wren = e.wren && (e.rd != 5'd0);
        q.push_back(m);
      end
    end
    #1;
    chk("valid_o", 32'(valid_o), 32'(q.size() > 0));
    chk("ready_o", 32'(ready_o), 32'(q.size() < 2));
    if (!rst) chk("rst_alu_data", alu_data_o, 32'd0);
    exp_fe = 1'b0;
    if (q.size() > 0) begin
      h = q[0];
      chk("alu_data", alu_data_o, h.alu);
      chk("st_data", st_data_o, h.st);
      chk("pc", pc_o, h.pc);
      chk("rd_addr", 32'(rd_addr_o), 32'(h.rd));
      chk("rd_wren", 32'(rd_wren_o), 32'(h.wren));
      chk("mem_wren", 32'(mem_wren_o), 32'(h.mw));
      chk("mem_rden", 32'(mem_rden_o), 32'(h.mr));
      chk("wb_sel", 32'(wb_sel_o), 32'(h.wb));
`ifdef EX_MEM_FWD_EN
      exp_fe = h.wren && (h.wb != 2'd1);
      if (exp_fe) begin
        chk("fwd_rd_addr", 32'(fwd_rd_addr_o), 32'(h.rd));
        chk("fwd_data", fwd_data_o, h.alu);
      end
`endif
    end
    chk("fwd_en", 32'(fwd_en_o), 32'(exp_fe));
`ifndef EX_MEM_FWD_EN
    chk("fwd_rd_addr_off", 32'(fwd_rd_addr_o), 32'd0);
    chk("fwd_data_off", fwd_data_o, 32'd0);
`endif
  endtask
  initial begin
    ent_t a;
    logic rst, f;
    step(1'b0, 1'b0, 1'b1, 1'b1, mk(32'h55, 5'd3, 2'd0));
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h66, 5'd3, 2'd0));
    step(1'b1, 1'b0, 1'b1, 1'b1, mk(32'h10, 5'd1, 2'd0));
    chk("first_accept", alu_data_o, 32'h10);
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b1, 1'b1, mk(32'(i), 5'd2, 2'd0));
    step(1'b1, 1'b0, 1'b0, 1'b1, rnd());
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(32'hA, 5'd4, 2'd0));
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(32'hB, 5'd4, 2'd0));
    chk("bp_ready_low", 32'(ready_o), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, mk(32'hC, 5'd4, 2'd0));
    step(1'b1, 1'b0, 1'b0, 1'b1, rnd());
    step(1'b1, 1'b0, 1'b0, 1'b1, rnd());
    a = mk(32'hDEADBEEF, 5'd0, 2'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, a);
    chk("x0_wren", 32'(rd_wren_o), 32'd0);
    step(1'b1, 1'b0, 1'b1, 1'b1, mk(32'h1234, 5'd5, 2'd0));
    step(1'b1, 1'b0, 1'b1, 1'b1, mk(32'h1234, 5'd5, 2'd1));
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(32'h77, 5'd6, 2'd2));
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(32'h88, 5'd7, 2'd3));
    step(1'b1, 1'b1, 1'b1, 1'b0, mk(32'h99, 5'd8, 2'd0));
    chk("flush_valid", 32'(valid_o), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, rnd());
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 63) != 0);
      f = ($urandom_range(0, 15) == 0);
      step(rst, f, 1'($urandom), ($urandom_range(0, 3) != 0), rnd());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_mem_pipe_reg.md
# ex_mem_pipe_reg

EX/MEM pipeline stage register of the RV32I core. It captures the execute-stage result (ALU/shifter output, store data, destination register and memory/writeback controls) and presents it to the memory stage one cycle later. It uses a valid/ready handshake with a two-entry skid buffer, so `ready_o` is a registered signal and full throughput holds under back-pressure. It also supplies the forwarding tap back to the execute-stage operand muxes.

## Interface
- `XLEN`, default 32: data width of result, store data and PC.
- `clk_i`  in  1  core clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, **synchronous, active-low**.
- `flush_i`  in  1  squash all held entries (branch mispredict or trap).
- `valid_i`  in  1  upstream EX result valid.
- `ready_o`  out  1  stage can accept; registered, equals NOT skid_valid.
- `alu_data_i`  in  XLEN  ALU or shifter result / effective address.
- `st_data_i`  in  XLEN  rs2 value for stores.
- `pc_i`  in  XLEN  instruction PC.
- `rd_addr_i`  in  5  destination register.
- `rd_wren_i`  in  1  register write enable.
- `mem_wren_i`, `mem_rden_i`  in  1 each  store / load request.
- `wb_sel_i`  in  2  writeback source (`wb_sel_e`).
- `valid_o`  out  1  head entry valid.
- `ready_i`  in  1  MEM stage accepts the head entry.
- `alu_data_o`, `st_data_o`, `pc_o`, `rd_addr_o`, `rd_wren_o`, `mem_wren_o`, `mem_rden_o`, `wb_sel_o`  out  same widths  head entry fields.
- `fwd_en_o`  out  1  head entry will write a nonzero register.
- `fwd_rd_addr_o`  out  5  forwarded destination.
- `fwd_data_o`  out  XLEN  forwarded value (`alu_data` of head).

## Operation
- Two entries: `main` (head, drives all outputs) and `skid`. `valid_o` = main_valid.
- Accept = `valid_i & ready_o`. Deliver = `valid_o & ready_i`.
- Main next state:
  - if Deliver and skid_valid: main <= skid, skid cleared;
  - else if (Deliver or !main_valid) and Accept: main <= input;
  - else if Deliver: main_valid <= 0.
- Skid captures the input when Accept occurs while main_valid and !Deliver. This can only happen when skid is empty, because `ready_o` = 0 whenever skid_valid = 1.
- At capture, `rd_wren` is forced to 0 when `rd_addr_i` = 0. `x0` is never written or forwarded.
- `fwd_en_o` = main_valid & rd_wren_o & (wb_sel_o ≠ WB_MEM). Loads are not forwardable from this stage.
- Flush: main_valid and skid_valid are cleared next cycle. A same-cycle Accept is discarded. Flush has priority over Accept and Deliver. Data fields are not cleared.
- Field ordering is preserved strictly FIFO. No reordering, no duplication.

## Timing
- Reset (`rst_ni` = 0 at an edge): main_valid = skid_valid = 0, all data/control regs = 0. So `valid_o` = 0, `fwd_en_o` = 0, `ready_o` = 1, all data outputs = 0. Handshakes in a reset cycle are ignored.
- Reset mid-operation drops both entries with no delivery.
- Latency: accept in cycle N gives `valid_o` in cycle N+1 when main is empty or delivering.
- Throughput: 1 entry/cycle while `ready_i` = 1.
- `ready_i` low with main full: the next accepted entry goes to skid. `ready_o` falls the cycle after, and rises the cycle after the skid drains.
- No combinational path from `ready_i` to `ready_o`, nor from any input to `valid_o`.

## Configuration
- `EX_MEM_FWD_EN` defined: forwarding outputs are driven as described.
- Undefined: `fwd_en_o` is tied 0, and `fwd_rd_addr_o` and `fwd_data_o` are tied 0. Ports remain present and no forwarding logic is synthesized.

## Structure
- Package `riscv_pkg` holds:
  - `wb_sel_e` (WB_ALU, WB_MEM, WB_PC4, WB_IMM);
  - `ex_mem_t` packed struct of all payload fields;
  - `REG_ZERO` = 5'd0.
- Sub-module `pipe_skid_buf`, parameterized by payload type, implements the main/skid handshake and flush. `ex_mem_pipe_reg` adds the x0 masking and the forwarding tap.

## Test plan
- **Reset:** hold `rst_ni` = 0 with `valid_i` = 1 → `valid_o` = 0, `ready_o` = 1, `alu_data_o` = 0. After release, first accept of 0x0000_0010 → `alu_data_o` = 0x10 next cycle.
- **Streaming:** `ready_i` = 1, 8 back-to-back entries with values 1..8 → outputs 1..8 on consecutive cycles, `ready_o` stays 1.
- **Back-pressure:** `ready_i` = 0 after entry A is held, accept B → `ready_o` = 0 next cycle. Raise `ready_i` → A then B delivered, `ready_o` = 1 again, no loss.
- **x0 masking:** `rd_addr_i` = 0, `rd_wren_i` = 1, data 0xDEAD_BEEF → `rd_wren_o` = 0, `fwd_en_o` = 0.
- **Forwarding:** `rd_addr_i` = 5, WB_ALU, data 0x1234 → `fwd_en_o` = 1, `fwd_rd_addr_o` = 5, `fwd_data_o` = 0x1234. Same with WB_MEM → `fwd_en_o` = 0. With `EX_MEM_FWD_EN` undefined → `fwd_en_o` always 0.
- **Flush:** main and skid full, `flush_i` = 1 with `valid_i` = 1 → next cycle `valid_o` = 0, `ready_o` = 1, and the flushed input is never delivered.
